// File: rtl/pipe_in_verify_pkg.sv
// Shared encodings and constants for the Pipe In verifier and its pattern generator.
// No logic here; imported by every file in this slice.
package pipe_in_verify_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  // pattern_gen modes; any other code selects the inverted counter
  localparam logic [2:0] PAT_COUNT = 3'd0;
  localparam logic [2:0] PAT_HASH  = 3'd1;
  localparam logic [2:0] PAT_WALK  = 3'd2;
  localparam logic [2:0] PAT_ALT   = 3'd3;

  localparam logic [31:0] HASH_STEP = 32'h9E37_79B9;

endpackage

// File: rtl/pipe_in_verify_if.sv
// Host Pipe In word stream: write strobe plus data toward the verifier, ready back to the host.
// Host (master) must only write while it has room; ready is a registered advisory level.
interface pipe_in_verify_if #(
  parameter int WIDTH = 32
);
  logic             pipe_in_write;
  logic [WIDTH-1:0] pipe_in_data;
  logic             pipe_in_ready;

  modport master (output pipe_in_write, output pipe_in_data, input pipe_in_ready);
  modport slave  (input pipe_in_write, input pipe_in_data, output pipe_in_ready);
endinterface

// File: rtl/pipe_in_verify_pattern_gen.sv
// Deterministic word sequence generator; dout is combinational from state, advances one word per enable.
// No backpressure: the consumer steps it with enable whenever it accepts a word.
module pattern_gen
  import pipe_in_verify_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       pattern,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] walk;
  logic             alt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      acc  <= '0;
      walk <= WIDTH'(1);
      alt  <= 1'b0;
    end else if (enable) begin
      cnt  <= cnt + WIDTH'(1);
      acc  <= acc + WIDTH'(HASH_STEP);
      walk <= {walk[WIDTH-2:0], walk[WIDTH-1]};
      alt  <= ~alt;
    end
  end

  always_comb begin
    dout = ~cnt;
    case (pattern)
      PAT_COUNT: dout = cnt;
      PAT_HASH:  dout = acc;
      PAT_WALK:  dout = walk;
      PAT_ALT:   dout = alt ? {(WIDTH/2){2'b10}} : {(WIDTH/2){2'b01}};
      default:   dout = ~cnt;
    endcase
  end

endmodule

// File: rtl/pipe_in_verify.sv
// Checks host Pipe In words against a regenerated pattern; counts words/errors, captures the first error.
// Accepts a word every cycle; pipe_in_ready is one cycle behind a throttled virtual FIFO level.
module pipe_in_verify
  import pipe_in_verify_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          LVL_W      = 16,
  parameter int unsigned READY_ROOM = 1024
) (
  input  logic              clk,
  input  logic              reset,
  pipe_in_verify_if.slave   pipe_in,
  input  logic              throttle_set,
  input  logic [31:0]       throttle_val,
  input  logic [2:0]        pattern,
  output logic [31:0]       word_count,
  output logic [31:0]       error_count,
  output logic [31:0]       first_err_index,
  output logic [WIDTH-1:0]  first_err_expected,
  output logic [WIDTH-1:0]  first_err_actual,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam logic [LVL_W-1:0] LVL_MAX = '1;

  logic [LVL_W-1:0] level;
  logic [31:0]      throttle;
  logic             ready_q;
  logic [WIDTH-1:0] pg_dout;
  logic             wr;
  logic             mismatch;
  logic [31:0]      room;
  state_e           st;

  assign wr       = pipe_in.pipe_in_write;
  assign mismatch = wr && (pipe_in.pipe_in_data != pg_dout);
  assign room     = 32'(LVL_MAX - level);

  assign pipe_in.pipe_in_ready = ready_q;
  assign state                 = st;

  pattern_gen #(.WIDTH(WIDTH)) pg0 (
    .clk     (clk),
    .reset   (reset),
    .enable  (wr),
    .pattern (pattern),
    .dout    (pg_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      throttle           <= throttle_val;
      level              <= '0;
      ready_q            <= 1'b0;
      word_count         <= '0;
      error_count        <= '0;
      first_err_index    <= '0;
      first_err_expected <= '0;
      first_err_actual   <= '0;
      overflow           <= 1'b0;
      st                 <= ST_IDLE;
    end else begin
      throttle <= throttle_set ? throttle_val : {throttle[0], throttle[31:1]};
      // ready reflects the level before this cycle's write/drain
      ready_q  <= (room >= READY_ROOM);

      case ({wr, throttle[0]})
        2'b10: begin
          if (level == LVL_MAX) overflow <= 1'b1;
          else                  level    <= level + 1'b1;
        end
        2'b01: begin
          if (level != '0) level <= level - 1'b1;
        end
        default: ;
      endcase

      if (wr) begin
        word_count <= word_count + 32'd1;
        if (mismatch) begin
          if (error_count != CNT_SAT) error_count <= error_count + 32'd1;
          if (error_count == '0) begin
            first_err_index    <= word_count;
            first_err_expected <= pg_dout;
            first_err_actual   <= pipe_in.pipe_in_data;
          end
          st <= ST_FAIL;
        end else if (st == ST_IDLE) begin
          st <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_in_verify.sv
// Directed and randomized checks of pipe_in_verify against a word-level reference model.
module tb_pipe_in_verify;

  localparam int LMAX = 65535;
  localparam int ROOM = 1024;

  logic        clk;
  logic        reset;
  logic        throttle_set;
  logic [31:0] throttle_val;
  logic [2:0]  pattern;
  logic [31:0] word_count, error_count, first_err_index;
  logic [31:0] first_err_expected, first_err_actual;
  logic        overflow;
  logic [1:0]  state;

  pipe_in_verify_if #(.WIDTH(32)) bus ();

  pipe_in_verify #(.WIDTH(32), .LVL_W(16), .READY_ROOM(1024)) dut (
    .clk                (clk),
    .reset              (reset),
    .pipe_in            (bus),
    .throttle_set       (throttle_set),
    .throttle_val       (throttle_val),
    .pattern            (pattern),
    .word_count         (word_count),
    .error_count        (error_count),
    .first_err_index    (first_err_index),
    .first_err_expected (first_err_expected),
    .first_err_actual   (first_err_actual),
    .overflow           (overflow),
    .state              (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_wc, m_err, m_fidx, m_fexp, m_fact, m_thr, m_n;
  int          m_level;
  logic        m_ovf, m_ready;
  int          m_state;

  function automatic logic [31:0] exp_word(input logic [2:0] md, input logic [31:0] n);
    case (md)
      3'd0:    return n;
      3'd1:    return n * 32'h9E37_79B9;
      3'd2:    return 32'h1 << n[4:0];
      3'd3:    return n[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      default: return ~n;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word_count"}, word_count, m_wc);
    chk({tag, ".error_count"}, error_count, m_err);
    chk({tag, ".first_idx"}, first_err_index, m_fidx);
    chk({tag, ".first_exp"}, first_err_expected, m_fexp);
    chk({tag, ".first_act"}, first_err_actual, m_fact);
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".ready"}, 32'(bus.pipe_in_ready), 32'(m_ready));
    chk({tag, ".level"}, 32'(dut.level), 32'(m_level));
  endtask

  task automatic do_reset(input logic [31:0] tval, input bit w);
    reset             = 1'b1;
    bus.pipe_in_write = w;
    bus.pipe_in_data  = $urandom;
    throttle_set      = 1'b0;
    throttle_val      = tval;
    @(posedge clk);
    m_wc = 0; m_err = 0; m_fidx = 0; m_fexp = 0; m_fact = 0;
    m_thr = tval; m_n = 0; m_level = 0; m_ovf = 0; m_ready = 0; m_state = 0;
    @(negedge clk);
    reset             = 1'b0;
    bus.pipe_in_write = 1'b0;
  endtask

  // one clock: optional write (flip != 0 corrupts the word), optional throttle load
  task automatic cyc(input bit w, input logic [31:0] flip, input bit tset, input logic [31:0] tval);
    logic [31:0] expw, d;
    bit drain;
    expw = exp_word(pattern, m_n);
    d    = expw ^ flip;
    bus.pipe_in_write = w;
    bus.pipe_in_data  = d;
    throttle_set      = tset;
    throttle_val      = tval;
    @(posedge clk);
    drain   = m_thr[0];
    m_ready = ((LMAX - m_level) >= ROOM);
    if (w && !drain) begin
      if (m_level == LMAX) m_ovf = 1'b1;
      else m_level = m_level + 1;
    end else if (!w && drain && m_level > 0) begin
      m_level = m_level - 1;
    end
    m_thr = tset ? tval : ((m_thr >> 1) | (m_thr << 31));
    if (w) begin
      if (d != expw) begin
        if (m_err == 0) begin
          m_fidx = m_wc; m_fexp = expw; m_fact = d;
        end
        if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
        m_state = 2;
      end else if (m_state == 0) begin
        m_state = 1;
      end
      m_wc = m_wc + 1;
      m_n  = m_n + 1;
    end
    @(negedge clk);
    bus.pipe_in_write = 1'b0;
    throttle_set      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; throttle_set = 1'b0; throttle_val = '0; pattern = 3'd0;
    bus.pipe_in_write = 1'b0; bus.pipe_in_data = '0;
    @(negedge clk);

    // reset state, then 1024 matching writes with no drain
    pattern = 3'd1;
    do_reset(32'h0, 1'b0);
    check_all("reset");
    for (int i = 0; i < 1024; i++) cyc(1'b1, 32'h0, 1'b0, 32'h0);
    check_all("t1_1024");
    chk("t1_state_run", 32'(state), 32'd1);

    // fill to max, probing the ready threshold on the way
    while (m_level != LMAX) begin
      cyc(1'b1, 32'h0, 1'b0, 32'h0);
      if (m_level >= LMAX - ROOM - 2 && m_level <= LMAX - ROOM + 2) check_all("t5_ready_edge");
    end
    check_all("t4_full");
    cyc(1'b1, 32'h0, 1'b0, 32'h0);
    check_all("t4_overflow");
    chk("t4_ovf_set", 32'(overflow), 32'd1);
    cyc(1'b1, 32'h0, 1'b1, 32'h1);
    cyc(1'b1, 32'h0, 1'b0, 32'h0);
    check_all("t4_wr_drain_max");
    for (int i = 0; i < 40; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0);
    check_all("t4_after_ring");

    // single corrupted word at index 5
    pattern = 3'd0;
    do_reset(32'h0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, (i == 5) ? 32'h1 : 32'h0, 1'b0, 32'h0);
    check_all("t2_err");
    chk("t2_idx", first_err_index, 32'd5);
    chk("t2_diff", first_err_expected ^ first_err_actual, 32'h1);

    // reset mid-burst after the error, then replay from seed
    cyc(1'b1, 32'h0, 1'b0, 32'h0);
    do_reset(32'h0, 1'b1);
    check_all("t6_reset");
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h0, 1'b0, 32'h0);
    check_all("t6_replay");

    // drain from level 10 with an all-ones throttle
    pattern = 3'd2;
    do_reset(32'h0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    check_all("t3_start");
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0);
    check_all("t3_empty");
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0);
    check_all("t3_stay0");

    // randomized traffic across pattern modes
    for (int r = 0; r < 6; r++) begin
      pattern = 3'($urandom_range(0, 7));
      do_reset($urandom, 1'b0);
      check_all("rnd_reset");
      for (int i = 0; i < 400; i++) begin
        cyc(($urandom % 4) != 0,
            (($urandom % 64) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0,
            ($urandom % 32) == 0, $urandom);
        check_all("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
